// File: rtl/fixed_point_pkg.sv
// Shared fixed-point helpers: default formats, signed sample type, saturation
// limits and the sign-extension overflow test used by the add/sub and diff stages.
package fixed_point_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_FRAC_W = 4;
  localparam int MAX_W      = 32;

  typedef logic signed [DEF_DATA_W-1:0] sample_t;

  // Largest positive value of a w-bit two's complement number, in MAX_W bits.
  function automatic logic signed [MAX_W-1:0] sat_max(input int w);
    logic signed [MAX_W-1:0] r;
    r = (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    return r;
  endfunction

  function automatic logic signed [MAX_W-1:0] sat_min(input int w);
    logic signed [MAX_W-1:0] r;
    r = ~sat_max(w);
    return r;
  endfunction

  // A one-bit-wider result fits the narrow width only if its top two bits agree.
  function automatic logic ext_overflow(input logic msb_ext, input logic msb);
    return msb_ext != msb;
  endfunction

endpackage

// File: rtl/fixed_point_delay_line.sv
// Past-sample shift register for the comb stage; advances only when i_shift is
// high, and o_oldest is the sample accepted DELAY shifts ago (zero after reset).
module fixed_point_delay_line #(
  parameter int DATA_W = 8,
  parameter int DELAY  = 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_shift,
  input  logic signed [DATA_W-1:0] i_data,
  output logic signed [DATA_W-1:0] o_oldest
);

  logic signed [DATA_W-1:0] taps [DELAY];

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DELAY; i++) taps[i] <= '0;
    end else if (i_shift) begin
      taps[0] <= i_data;
      for (int i = 1; i < DELAY; i++) taps[i] <= taps[i-1];
    end
  end

  assign o_oldest = taps[DELAY-1];

endmodule

// File: rtl/fixed_point_diff_stream.sv
// Streaming comb stage y[n] = x[n] - x[n-DELAY] with a single registered
// valid/ready output. Define FIXED_DIFF_SATURATE_EN to clamp on overflow instead of wrapping.
module fixed_point_diff_stream
  import fixed_point_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int DELAY  = 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic signed [DATA_W-1:0] i_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_overflow
);

  localparam int CNT_W = $clog2(DELAY + 1);

  generate
    if (DELAY < 1 || DELAY > 16) begin : g_bad_delay
      $error("fixed_point_diff_stream: DELAY must be in 1..16");
    end
    if (FRAC_W < 0 || FRAC_W >= DATA_W) begin : g_bad_frac
      $error("fixed_point_diff_stream: FRAC_W must be in 0..DATA_W-1");
    end
  endgenerate

  logic                     accept;
  logic                     fire;
  logic signed [DATA_W-1:0] oldest;
  logic signed [DATA_W:0]   diff;
  logic                     ovf;
  logic signed [DATA_W-1:0] result;
  logic [CNT_W-1:0]         prime_cnt;
  logic                     f_primed;
  logic                     f_past_valid;

  assign o_ready = !o_valid || i_ready;
  assign accept  = i_valid && o_ready;
  assign fire    = o_valid && i_ready;

  fixed_point_delay_line #(
    .DATA_W (DATA_W),
    .DELAY  (DELAY)
  ) u_delay_line (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_shift   (accept),
    .i_data    (i_data),
    .o_oldest  (oldest)
  );

  // One extra bit holds every possible difference of two DATA_W samples exactly.
  assign diff = {i_data[DATA_W-1], i_data} - {oldest[DATA_W-1], oldest};
  assign ovf  = ext_overflow(diff[DATA_W], diff[DATA_W-1]);

`ifdef FIXED_DIFF_SATURATE_EN
  localparam logic signed [MAX_W-1:0] SAT_HI = sat_max(DATA_W);
  localparam logic signed [MAX_W-1:0] SAT_LO = sat_min(DATA_W);

  always_comb begin
    result = diff[DATA_W-1:0];
    if (ovf) result = diff[DATA_W] ? SAT_LO[DATA_W-1:0] : SAT_HI[DATA_W-1:0];
  end
`else
  always_comb begin
    result = diff[DATA_W-1:0];
  end
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_overflow <= 1'b0;
    end else if (accept) begin
      o_valid    <= 1'b1;
      o_data     <= result;
      o_overflow <= ovf;
    end else if (fire) begin
      o_valid    <= 1'b0;
    end
  end

  // Priming status only; the zero-cleared delay line already makes y = x early on.
  assign f_primed = (prime_cnt == CNT_W'(DELAY));

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      prime_cnt <= '0;
    end else if (accept && !f_primed) begin
      prime_cnt <= prime_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    f_past_valid <= 1'b1;
  end

  a_unprimed_history_zero: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    !f_primed |-> oldest == '0);

  a_stall_holds_output: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    f_past_valid && $past(i_reset_n && o_valid && !i_ready)
      |-> o_valid && $stable(o_data) && $stable(o_overflow));

  a_valid_rises_on_accept: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    f_past_valid && o_valid && !$past(o_valid) |-> $past(accept && i_reset_n));

endmodule
